conware_ctrl: RTL and testbench

CONWARE_CTRL -- requirements
Module: conware_ctrl

---
 rtl/conware_pkg.sv | 36 +++
 rtl/conware_beat_counter.sv | 48 ++++
 rtl/conware_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_conware_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conware_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conware_pkg
//  Description : Shared definitions for the conware controller and datapath:
//                FSM state encoding and grid size / address width derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package conware_pkg;

    // Controller states. The width is fixed so the encoding is stable across
    // tools and matches anything that decodes the state elsewhere.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        STEP  = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Width of the post-step wait counter; holds latencies 1..15.
    localparam int C_STEP_LAT_W = 4;

    // Number of cells in a WIDTH x HEIGHT grid.
    function automatic int calc_npix(input int width, input int height);
        return width * height;
    endfunction

    // Buffer address width. A one-cell grid still gets a 1-bit address so
    // that no zero-width vectors appear.
    function automatic int calc_idxw(input int npix);
        return (npix > 1) ? $clog2(npix) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conware_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : beat_counter
//  Description : Modulo-NPIX beat counter used as the pixel buffer address.
//                Counts accepted beats, wraps from NPIX-1 back to 0.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_clr         - synchronous clear (priority over i_en)
//                i_en          - advance by one
//                o_count       - current address
//                o_at_last     - o_count == NPIX-1
//                o_wrap        - advancing this cycle from NPIX-1 to 0
//  Revision    : 1.0 - initial release
// ============================================================================
module beat_counter #(
    parameter int NPIX = 16,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_en,
    output logic [IDXW-1:0] o_count,
    output logic            o_at_last,
    output logic            o_wrap
);

    localparam logic [IDXW-1:0] C_LAST = IDXW'(NPIX - 1);

    logic [IDXW-1:0] r_count;
    logic            w_at_last;

    assign w_at_last = (r_count == C_LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            // NPIX need not be a power of two, so wrap explicitly.
            r_count <= w_at_last ? '0 : r_count + IDXW'(1);
        end
    end

    assign o_count   = r_count;
    assign o_at_last = w_at_last;
    assign o_wrap    = i_en & w_at_last;

endmodule
`default_nettype wire

// File: rtl/conware_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conware_ctrl
//  Description : Job controller for the conware life engine. Loads one grid
//                frame from the input stream into the pixel buffer, issues
//                num_gens step pulses (each followed by STEP_LAT idle cycles
//                while the datapath settles), then drains the grid to the
//                output stream and pulses done.
//  Ports       : clk, rst                    - clock, sync active-high reset
//                start, num_gens, abort      - job control
//                S_AXIS_TVALID/TLAST/TREADY  - input stream handshake
//                M_AXIS_TVALID/TLAST/TREADY  - output stream handshake
//                pix_idx, wr_en              - pixel buffer address / write
//                step                        - latch next generation
//                busy, done, err_tlast       - status
//                gen_count                   - generations completed
//  Revision    : 1.0 - initial release
// ============================================================================
module conware_ctrl
    import conware_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int HEIGHT   = 32,
    parameter  int GEN_W    = 16,
    parameter  int STEP_LAT = 2,
    localparam int NPIX     = calc_npix(WIDTH, HEIGHT),
    localparam int IDXW     = calc_idxw(NPIX)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             start,
    input  logic [GEN_W-1:0] num_gens,
    input  logic             abort,

    input  logic             S_AXIS_TVALID,
    input  logic             S_AXIS_TLAST,
    output logic             S_AXIS_TREADY,

    output logic             M_AXIS_TVALID,
    output logic             M_AXIS_TLAST,
    input  logic             M_AXIS_TREADY,

    output logic [IDXW-1:0]  pix_idx,
    output logic             wr_en,
    output logic             step,

    output logic             busy,
    output logic             done,
    output logic             err_tlast,
    output logic [GEN_W-1:0] gen_count
);

    // WAIT is entered with the counter preloaded to STEP_LAT-1 and left when
    // it reaches zero, giving exactly STEP_LAT cycles in WAIT.
    localparam logic [C_STEP_LAT_W-1:0] C_WAIT_INIT = C_STEP_LAT_W'(STEP_LAT - 1);

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic                    r_s_tready;
    logic                    r_m_tvalid;
    logic                    r_step;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err_tlast;
    logic [GEN_W-1:0]        r_gen_count;
    logic [GEN_W-1:0]        r_num_gens;
    logic [C_STEP_LAT_W-1:0] r_wait_cnt;

    // ------------------------------------------------------------------
    // Handshakes and beat counter control
    // ------------------------------------------------------------------
    logic             w_wr_en;
    logic             w_m_fire;
    logic             w_abort;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic [IDXW-1:0]  w_count;
    logic             w_at_last;
    logic             w_wrap;
    logic [GEN_W-1:0] w_gen_next;

    assign w_wr_en    = S_AXIS_TVALID & r_s_tready;
    assign w_m_fire   = r_m_tvalid & M_AXIS_TREADY;
    assign w_abort    = abort & (r_state != IDLE);
    // Input and output phases never overlap (TREADY only in LOAD, TVALID
    // only in DRAIN), so one counter serves both and its wrap flag always
    // belongs to the phase currently active.
    assign w_cnt_en   = w_wr_en | w_m_fire;
    assign w_cnt_clr  = w_abort | ((r_state == IDLE) & start);
    assign w_gen_next = r_gen_count + GEN_W'(1);

    beat_counter #(
        .NPIX (NPIX),
        .IDXW (IDXW)
    ) u_beat_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .o_count   (w_count),
        .o_at_last (w_at_last),
        .o_wrap    (w_wrap)
    );

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_s_tready  <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_step      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_tlast <= 1'b0;
            r_gen_count <= '0;
            r_num_gens  <= '0;
            r_wait_cnt  <= '0;
        end else if (w_abort) begin
            // Cancel quietly: no done pulse, gen_count and err_tlast keep
            // their values for software to inspect.
            r_state    <= IDLE;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_step     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_num_gens  <= num_gens;
                        r_gen_count <= '0;
                        r_err_tlast <= 1'b0;
                        r_s_tready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= LOAD;
                    end
                end

                LOAD: begin
                    if (w_wr_en) begin
                        // TLAST is only checked; framing follows beat count.
                        if (S_AXIS_TLAST != w_at_last) begin
                            r_err_tlast <= 1'b1;
                        end
                        if (w_wrap) begin
                            r_s_tready <= 1'b0;
                            if (r_num_gens == '0) begin
                                r_m_tvalid <= 1'b1;
                                r_state    <= DRAIN;
                            end else begin
                                r_step  <= 1'b1;
                                r_state <= STEP;
                            end
                        end
                    end
                end

                STEP: begin
                    r_step     <= 1'b0;
                    r_wait_cnt <= C_WAIT_INIT;
                    r_state    <= WAIT;
                end

                WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_gen_count <= w_gen_next;
                        if (w_gen_next == r_num_gens) begin
                            r_m_tvalid <= 1'b1;
                            r_state    <= DRAIN;
                        end else begin
                            r_step  <= 1'b1;
                            r_state <= STEP;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - C_STEP_LAT_W'(1);
                    end
                end

                DRAIN: begin
                    if (w_wrap) begin
                        r_m_tvalid <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_s_tready <= 1'b0;
                    r_m_tvalid <= 1'b0;
                    r_step     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign S_AXIS_TREADY = r_s_tready;
    assign M_AXIS_TVALID = r_m_tvalid;
    // Both terms are registers, so TLAST holds steady through a stall.
    assign M_AXIS_TLAST  = r_m_tvalid & w_at_last;
    assign pix_idx       = w_count;
    assign wr_en         = w_wr_en;
    assign step          = r_step;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err_tlast     = r_err_tlast;
    assign gen_count     = r_gen_count;

endmodule
`default_nettype wire

// File: tb/tb_conware_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conware_ctrl
//  Description : Self-checking bench for conware_ctrl on a 4x4 grid with
//                STEP_LAT=2. Jobs are driven with randomized valid/ready
//                patterns and checked against job-level expectations: beat
//                order, step cadence, drain latency, stall stability,
//                done pulse, error flag, abort and reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conware_ctrl;

    localparam int C_W    = 4;
    localparam int C_H    = 4;
    localparam int C_GW   = 16;
    localparam int C_SL   = 2;
    localparam int C_NP   = C_W * C_H;
    localparam int C_IW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [C_GW-1:0] num_gens;
    logic            abort;
    logic            S_AXIS_TVALID;
    logic            S_AXIS_TLAST;
    logic            S_AXIS_TREADY;
    logic            M_AXIS_TVALID;
    logic            M_AXIS_TLAST;
    logic            M_AXIS_TREADY;
    logic [C_IW-1:0] pix_idx;
    logic            wr_en;
    logic            step;
    logic            busy;
    logic            done;
    logic            err_tlast;
    logic [C_GW-1:0] gen_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    conware_ctrl #(
        .WIDTH    (C_W),
        .HEIGHT   (C_H),
        .GEN_W    (C_GW),
        .STEP_LAT (C_SL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_gens      (num_gens),
        .abort         (abort),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .pix_idx       (pix_idx),
        .wr_en         (wr_en),
        .step          (step),
        .busy          (busy),
        .done          (done),
        .err_tlast     (err_tlast),
        .gen_count     (gen_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // All outputs at their reset/idle values.
    task automatic check_quiet(input string pfx);
        check({pfx, "_busy"},   busy,          0);
        check({pfx, "_done"},   done,          0);
        check({pfx, "_step"},   step,          0);
        check({pfx, "_sready"}, S_AXIS_TREADY, 0);
        check({pfx, "_mvalid"}, M_AXIS_TVALID, 0);
        check({pfx, "_mlast"},  M_AXIS_TLAST,  0);
        check({pfx, "_idx"},    pix_idx,       0);
    endtask

    // One job. Inputs change on the falling edge; sampling 1ns later shows
    // what the next rising edge will act on.
    //   ng        generations requested
    //   bad       input beat carrying a wrong TLAST (-1: none)
    //   abort_at  abort after this many accepted beats (-1: none)
    //   rdy_mode  0: ready always, 1: pattern 1,0,0,1, 2: random
    //   full_rate input valid every cycle
    //   noise     randomly re-assert start while the job is loading
    task automatic run_job(input int ng, input int bad, input int abort_at,
                           input int rdy_mode, input bit full_rate, input bit noise);
        int in_cnt = 0, out_cnt = 0, steps = 0, dones = 0, it = 0;
        int last_in_it = -1, first_mv_it = -1, last_step_it = -1;
        int st_idx = 0, st_last = 0;
        bit stalled = 1'b0, err_chk = 1'b0, finished = 1'b0, aborted = 1'b0;

        @(negedge clk);
        start    = 1'b1;
        num_gens = C_GW'(ng);
        while (!finished && it < 600) begin
            @(negedge clk);
            it++;
            start         = noise && (in_cnt < C_NP) && ($urandom % 3 == 0);
            num_gens      = start ? C_GW'(ng + 5) : C_GW'(ng);
            S_AXIS_TVALID = (in_cnt < C_NP) && (full_rate || ($urandom % 4 != 0));
            S_AXIS_TLAST  = (in_cnt == C_NP - 1) ^ (in_cnt == bad);
            case (rdy_mode)
                0:       M_AXIS_TREADY = 1'b1;
                1:       M_AXIS_TREADY = (it % 4 == 0) || (it % 4 == 3);
                default: M_AXIS_TREADY = $urandom_range(0, 1) == 1;
            endcase
            abort = (abort_at >= 0) && (in_cnt == abort_at);
            if (abort) S_AXIS_TVALID = 1'b0;
            #1;
            if (err_chk) begin
                check("err_tlast_set", err_tlast, 1);
                err_chk = 1'b0;
            end
            if (abort) begin
                aborted = 1'b1;
                break;
            end
            if (wr_en) begin
                check("in_idx", pix_idx, in_cnt);
                if (bad >= 0 && in_cnt <= bad) check("err_early", err_tlast, 0);
                if (in_cnt == bad) err_chk = 1'b1;
                if (in_cnt == C_NP - 1) last_in_it = it;
                in_cnt++;
            end
            if (step) begin
                if (last_step_it >= 0) check("step_gap", it - last_step_it, 1 + C_SL);
                else                   check("first_step", it - last_in_it, 1);
                last_step_it = it;
                steps++;
            end
            if (M_AXIS_TVALID) begin
                if (first_mv_it < 0) begin
                    first_mv_it = it;
                    check("drain_lat", it - last_in_it, 1 + (1 + C_SL) * ng);
                end
                if (stalled) begin
                    check("stall_idx",  pix_idx,      st_idx);
                    check("stall_last", M_AXIS_TLAST, st_last);
                end
                stalled = !M_AXIS_TREADY;
                st_idx  = pix_idx;
                st_last = M_AXIS_TLAST;
                if (M_AXIS_TREADY) begin
                    check("out_idx",  pix_idx,      out_cnt);
                    check("out_last", M_AXIS_TLAST, (out_cnt == C_NP - 1) ? 1 : 0);
                    out_cnt++;
                end
            end
            if (done) begin
                dones++;
                finished = 1'b1;
            end
        end
        start         = 1'b0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;

        if (aborted) begin
            @(negedge clk);
            abort = 1'b0;
            #1;
            check_quiet("abort");
            check("abort_gen_hold", gen_count, 0);
            repeat (4) begin
                @(negedge clk);
                #1;
                if (done) dones++;
            end
            check("abort_no_done", dones, 0);
        end else begin
            check("job_finished", finished, 1);
            check("steps",        steps,     ng);
            check("gen_count",    gen_count, ng);
            check("in_beats",     in_cnt,    C_NP);
            check("out_beats",    out_cnt,   C_NP);
            check("err_tlast",    err_tlast, (bad >= 0) ? 1 : 0);
            @(negedge clk);
            #1;
            check("done_width", done,      0);
            check("idle_busy",  busy,      0);
            check("gen_hold",   gen_count, ng);
        end
    endtask

    // Reset while waiting after a step; start and abort asserted alongside
    // must lose to reset.
    task automatic rst_in_wait();
        int k = 0;
        bit seen = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        num_gens = C_GW'(3);
        @(negedge clk);
        start         = 1'b0;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TLAST  = 1'b0;   // wrong on beat 15, so err_tlast gets set
        M_AXIS_TREADY = 1'b1;
        while (!seen && k < 100) begin
            #1;
            if (step) seen = 1'b1;
            @(negedge clk);
            k++;
        end
        S_AXIS_TVALID = 1'b0;
        #1;
        check("rw_step_seen", seen, 1);
        check("rw_busy",      busy, 1);
        check("rw_err_pre",   err_tlast, 1);
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #1;
        check_quiet("rw");
        check("rw_err",   err_tlast, 0);
        check("rw_wr_en", wr_en,     0);
        check("rw_gen",   gen_count, 0);
        @(negedge clk);
        #1;
        check("rw_no_start", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        num_gens      = '0;
        abort         = 1'b0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("rst");
        check("rst_err", err_tlast, 0);
        check("rst_gen", gen_count, 0);
        rst = 1'b0;

        run_job(3, -1, -1, 0, 1'b1, 1'b0);   // nominal full-rate job
        run_job(0, -1, -1, 0, 1'b1, 1'b0);   // no generations
        run_job(2,  7, -1, 0, 1'b1, 1'b0);   // early TLAST on beat 7
        run_job(1, -1, -1, 1, 1'b1, 1'b0);   // output stalls 1,0,0,1
        run_job(2, -1,  5, 0, 1'b0, 1'b0);   // abort at beat 5
        run_job(1, -1, -1, 0, 1'b1, 1'b0);   // restart after abort
        run_job(2, 15, -1, 2, 1'b0, 1'b1);   // missing TLAST, start noise
        rst_in_wait();

        for (int j = 0; j < 6; j++) begin
            int ng, bad;
            ng  = int'($urandom_range(0, 4));
            bad = ($urandom % 2 == 0) ? int'($urandom_range(0, C_NP - 1)) : -1;
            run_job(ng, bad, -1, 2, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
